// File: rtl/riscv_cg_pkg.sv
// ----------------------------------------------------------------------------
// riscv_cg_pkg
//   Shared types and defaults for the riscv_clkgate_ctrl clock-enable
//   controller: the sleep-handshake state enum, default parameter values and a
//   small width helper used to size the internal down/up counters.
//   Optional feature macro used by the controller: RISCV_CG_STATS_EN.
// ----------------------------------------------------------------------------
package riscv_cg_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_DRAIN = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_t;

    localparam int CG_NUM_STAGES_DEF  = 5;
    localparam int CG_IDLE_THRESH_DEF = 8;
    localparam int CG_WAKE_LAT_DEF    = 2;
    localparam int CG_STAT_W_DEF      = 32;

    // Number of bits needed to hold the values 0..max_val (never less than 1).
    function automatic int cg_cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/riscv_cg_idle_cnt.sv
// ----------------------------------------------------------------------------
// riscv_cg_idle_cnt
//   Saturating idle-cycle counter for one pipeline stage. Counts up while
//   i_inc is high, sticks at THRESH, and returns to zero whenever i_clr is high
//   (clear wins over increment).
// Ports
//   i_clk    core clock
//   i_reset  asynchronous active-high reset
//   i_inc    count this cycle (stage idle and fine-gating active)
//   i_clr    force count to zero (stage busy, or wake-up in progress)
//   o_sat    count has reached THRESH
// ----------------------------------------------------------------------------
module riscv_cg_idle_cnt
    import riscv_cg_pkg::*;
#(
    parameter int THRESH = CG_IDLE_THRESH_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int              CNT_W   = cg_cnt_width(THRESH);
    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(THRESH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (i_inc && (r_cnt != SAT_VAL)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_sat = (r_cnt == SAT_VAL);

endmodule

// File: rtl/riscv_clkgate_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_clkgate_ctrl
//   Clock-enable controller for the 5-stage riscv_cpu pipeline. Produces one
//   ICG enable per stage.
//   Fine grain : a stage is gated after IDLE_THRESH consecutive cycles in which
//                neither it nor its upstream neighbour holds a valid
//                instruction; it re-opens combinationally the moment either
//                valid rises, so the arriving instruction is clocked in on the
//                same edge.
//   Coarse     : WFI handshake RUN -> DRAIN -> GATED -> WAKE -> RUN. Fetch is
//                held while draining, all enables drop once the pipe is empty,
//                and an interrupt (or withdrawal of the request) wakes the core
//                with all enables on for WAKE_LAT cycles before fetch resumes.
// Ports
//   i_clk            core clock (ungated)
//   i_reset          asynchronous active-high reset
//   i_stage_valid    per-stage valid (bit 0 = IF, NUM_STAGES-1 = WB)
//   i_sleep_req      WFI retired, level held until ack or abort
//   i_irq_pending    any enabled interrupt pending (wake source)
//   i_force_on       debug/scan override, forces all enables to 1
//   o_stage_clk_en   per-stage ICG enable
//   o_fetch_hold     blocks IF from issuing new fetches
//   o_sleep_ack      core fully gated
//   o_gated_cycles   cycles spent in GATED, saturating (only when the
//                    RISCV_CG_STATS_EN macro is defined)
// ----------------------------------------------------------------------------
module riscv_clkgate_ctrl
    import riscv_cg_pkg::*;
#(
    parameter int NUM_STAGES  = CG_NUM_STAGES_DEF,
    parameter int IDLE_THRESH = CG_IDLE_THRESH_DEF,
    parameter int WAKE_LAT    = CG_WAKE_LAT_DEF
`ifdef RISCV_CG_STATS_EN
    ,
    parameter int STAT_W      = CG_STAT_W_DEF
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_STAGES-1:0] i_stage_valid,
    input  logic                  i_sleep_req,
    input  logic                  i_irq_pending,
    input  logic                  i_force_on,
    output logic [NUM_STAGES-1:0] o_stage_clk_en,
    output logic                  o_fetch_hold,
    output logic                  o_sleep_ack
`ifdef RISCV_CG_STATS_EN
    ,
    output logic [STAT_W-1:0]     o_gated_cycles
`endif
);

    localparam int               WL_W      = cg_cnt_width(WAKE_LAT);
    // The counter runs WAKE_LAT-1 .. 0, giving exactly WAKE_LAT cycles in WAKE.
    localparam logic [WL_W-1:0]  WAKE_LOAD = WL_W'(WAKE_LAT - 1);

    cg_state_t               r_state;
    cg_state_t               w_state_next;
    logic [WL_W-1:0]         r_wake_cnt;
    logic                    w_wake_done;
    logic                    w_fine_active;
    logic                    w_wake_clr;
    logic [NUM_STAGES-1:1]   w_idle;
    logic [NUM_STAGES-1:1]   w_sat;
    logic [NUM_STAGES-1:0]   w_fine_en;
    logic [NUM_STAGES-1:0]   w_state_en;

    assign w_wake_done   = (r_wake_cnt == '0);
    assign w_fine_active = (r_state == CG_RUN) || (r_state == CG_DRAIN);
    assign w_wake_clr    = (r_state == CG_WAKE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= CG_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CG_RUN: begin
                if (i_sleep_req && !i_irq_pending) begin
                    w_state_next = CG_DRAIN;
                end
            end
            CG_DRAIN: begin
                // Abort is checked first so a late interrupt never lets the
                // core reach GATED.
                if (i_irq_pending || !i_sleep_req) begin
                    w_state_next = CG_RUN;
                end else if (i_stage_valid == '0) begin
                    w_state_next = CG_GATED;
                end
            end
            CG_GATED: begin
                if (i_irq_pending || !i_sleep_req) begin
                    w_state_next = CG_WAKE;
                end
            end
            CG_WAKE: begin
                if (w_wake_done) begin
                    w_state_next = CG_RUN;
                end
            end
            default: w_state_next = CG_RUN;
        endcase
    end

    always_comb begin
        o_fetch_hold = 1'b1;
        o_sleep_ack  = 1'b0;
        w_state_en   = '1;
        case (r_state)
            CG_RUN: begin
                o_fetch_hold = 1'b0;
                w_state_en   = w_fine_en;
            end
            CG_DRAIN: begin
                w_state_en   = w_fine_en;
            end
            CG_GATED: begin
                o_sleep_ack  = 1'b1;
                w_state_en   = '0;
            end
            CG_WAKE: begin
                w_state_en   = '1;
            end
            default: begin
                o_fetch_hold = 1'b0;
                w_state_en   = '1;
            end
        endcase
        // Override sits after the FSM decode; state and counters are untouched.
        o_stage_clk_en = i_force_on ? '1 : w_state_en;
    end

    // Reloaded every cycle outside WAKE so it is already primed on entry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wake_cnt <= '0;
        end else if (r_state != CG_WAKE) begin
            r_wake_cnt <= WAKE_LOAD;
        end else if (!w_wake_done) begin
            r_wake_cnt <= r_wake_cnt - 1'b1;
        end
    end

    // ------------------------------------------------- fine-grain gating
    // IF has no upstream neighbour: always on while running, and while
    // draining it only needs a clock if it still holds an instruction.
    assign w_fine_en[0] = (r_state == CG_RUN) ? 1'b1 : i_stage_valid[0];

    genvar gi;
    generate
        for (gi = 1; gi < NUM_STAGES; gi++) begin : g_stage
            assign w_idle[gi] = !i_stage_valid[gi] && !i_stage_valid[gi-1];

            riscv_cg_idle_cnt #(
                .THRESH (IDLE_THRESH)
            ) u_idle_cnt (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_inc   (w_idle[gi] && w_fine_active),
                .i_clr   (!w_idle[gi] || w_wake_clr),
                .o_sat   (w_sat[gi])
            );

            // Valid terms bypass the counter so wake-up costs no cycle.
            assign w_fine_en[gi] = !w_sat[gi] || i_stage_valid[gi-1] || i_stage_valid[gi];
        end
    endgenerate

    // ------------------------------------------------------- statistics
`ifdef RISCV_CG_STATS_EN
    logic [STAT_W-1:0] r_gated_cycles;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_gated_cycles <= '0;
        end else if ((r_state == CG_GATED) && (r_gated_cycles != '1)) begin
            r_gated_cycles <= r_gated_cycles + 1'b1;
        end
    end

    assign o_gated_cycles = r_gated_cycles;
`endif

endmodule
